// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline widths and control-bit layout
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int ALUOP_W = 4;
    localparam int CTRL_W  = 5;

    // Bit positions inside the {alu_src, mem_read, mem_write, reg_write, mem_to_reg} control word
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, writeback and execute signals of the ID/EX register
interface id_ex_stage_if #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int ADDR_W  = mips_pkg::ADDR_W,
    parameter int ALUOP_W = mips_pkg::ALUOP_W,
    parameter int CNT_W   = 16
);
    logic                        id_valid;
    logic [ADDR_W-1:0]           id_rs;
    logic [ADDR_W-1:0]           id_rt;
    logic [ADDR_W-1:0]           id_rd;
    logic                        id_use_rs;
    logic                        id_use_rt;
    logic [DATA_W-1:0]           id_data1;
    logic [DATA_W-1:0]           id_data2;
    logic [DATA_W-1:0]           id_imm;
    logic [DATA_W-1:0]           id_pc4;
    logic [ALUOP_W-1:0]          id_aluop;
    logic [mips_pkg::CTRL_W-1:0] id_ctrl;
    logic                        wb_reg_write;
    logic [ADDR_W-1:0]           wb_addr;
    logic [DATA_W-1:0]           wb_data;
    logic                        flush;
    logic                        hold;
    logic                        stall_id;
    logic                        ex_valid;
    logic [ADDR_W-1:0]           ex_rs;
    logic [ADDR_W-1:0]           ex_rt;
    logic [ADDR_W-1:0]           ex_rd;
    logic [DATA_W-1:0]           ex_data1;
    logic [DATA_W-1:0]           ex_data2;
    logic [DATA_W-1:0]           ex_imm;
    logic [DATA_W-1:0]           ex_pc4;
    logic [ALUOP_W-1:0]          ex_aluop;
    logic [mips_pkg::CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]            bubble_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
               id_data1, id_data2, id_imm, id_pc4, id_aluop, id_ctrl,
               wb_reg_write, wb_addr, wb_data, flush, hold,
        input  stall_id, ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2,
               ex_imm, ex_pc4, ex_aluop, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
               id_data1, id_data2, id_imm, id_pc4, id_aluop, id_ctrl,
               wb_reg_write, wb_addr, wb_data, flush, hold,
        output stall_id, ex_valid, ex_rs, ex_rt, ex_rd, ex_data1, ex_data2,
               ex_imm, ex_pc4, ex_aluop, ex_ctrl, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use hazard and decode stall generation
module hazard_detect #(
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              hold_i,
    output logic              ld_use_o,
    output logic              stall_o
);

    logic load_in_ex;
    logic rs_dep;
    logic rt_dep;

    // Register 0 is hardwired, so a load targeting it never produces a dependency
    assign load_in_ex = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0);
    assign rs_dep     = id_use_rs_i & (id_rs_i == ex_rd_i);
    assign rt_dep     = id_use_rt_i & (id_rt_i == ex_rd_i);
    assign ld_use_o   = load_in_ex & id_valid_i & (rs_dep | rt_dep);
    assign stall_o    = ld_use_o | hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with writeback bypass, load-use bubbles and flush/hold
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int ADDR_W  = mips_pkg::ADDR_W,
    parameter int ALUOP_W = mips_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic                ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0]   ex_rs_q, ex_rs_d;
    logic [ADDR_W-1:0]   ex_rt_q, ex_rt_d;
    logic [ADDR_W-1:0]   ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0]   ex_data1_q, ex_data1_d;
    logic [DATA_W-1:0]   ex_data2_q, ex_data2_d;
    logic [DATA_W-1:0]   ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0]   ex_pc4_q, ex_pc4_d;
    logic [ALUOP_W-1:0]  ex_aluop_q, ex_aluop_d;
    logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic                ld_use;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;

    hazard_detect #(.ADDR_W(ADDR_W)) u_hazard (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q[CTRL_MEM_READ]),
        .ex_rd_i       (ex_rd_q),
        .id_valid_i    (bus.id_valid),
        .id_use_rs_i   (bus.id_use_rs),
        .id_use_rt_i   (bus.id_use_rt),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .hold_i        (bus.hold),
        .ld_use_o      (ld_use),
        .stall_o       (bus.stall_id)
    );

    // Register file reads and writes share a cycle; the write is not yet visible on the read ports
    always_comb begin
        op1 = bus.id_data1;
        op2 = bus.id_data2;
        if (bus.id_rs == '0) begin
            op1 = '0;
        end else if (bus.wb_reg_write && bus.wb_addr == bus.id_rs) begin
            op1 = bus.wb_data;
        end
        if (bus.id_rt == '0) begin
            op2 = '0;
        end else if (bus.wb_reg_write && bus.wb_addr == bus.id_rt) begin
            op2 = bus.wb_data;
        end
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        ex_data1_d   = ex_data1_q;
        ex_data2_d   = ex_data2_q;
        ex_imm_d     = ex_imm_q;
        ex_pc4_d     = ex_pc4_q;
        ex_aluop_d   = ex_aluop_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush || (!bus.hold && ld_use)) begin
            ex_valid_d = 1'b0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
            ex_data1_d = '0;
            ex_data2_d = '0;
            ex_imm_d   = '0;
            ex_pc4_d   = '0;
            ex_aluop_d = '0;
            ex_ctrl_d  = BUBBLE_CTRL;
            // Only load-use bubbles are counted; flushes are branch cost, not hazard cost
            if (!bus.flush && bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!bus.hold) begin
            ex_valid_d = bus.id_valid;
            ex_rs_d    = bus.id_rs;
            ex_rt_d    = bus.id_rt;
            ex_rd_d    = bus.id_rd;
            ex_data1_d = op1;
            ex_data2_d = op2;
            ex_imm_d   = bus.id_imm;
            ex_pc4_d   = bus.id_pc4;
            ex_aluop_d = bus.id_aluop;
            ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : BUBBLE_CTRL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_data1_q   <= '0;
            ex_data2_q   <= '0;
            ex_imm_q     <= '0;
            ex_pc4_q     <= '0;
            ex_aluop_q   <= '0;
            ex_ctrl_q    <= BUBBLE_CTRL;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_data1_q   <= ex_data1_d;
            ex_data2_q   <= ex_data2_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_aluop_q   <= ex_aluop_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_data1   = ex_data1_q;
    assign bus.ex_data2   = ex_data2_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_pc4     = ex_pc4_q;
    assign bus.ex_aluop   = ex_aluop_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a rule-level reference model
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.CNT_W(CW)) bus ();
    id_ex_stage #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic        v;
        logic [5:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm, pc4;
        logic [3:0]  op;
        logic [4:0]  ctrl;
        logic [CW-1:0] cnt;
    } st_t;

    st_t m;
    st_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic cmp(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic st_t dut_st();
        st_t r;
        r.v = bus.ex_valid; r.rs = bus.ex_rs; r.rt = bus.ex_rt; r.rd = bus.ex_rd;
        r.d1 = bus.ex_data1; r.d2 = bus.ex_data2; r.imm = bus.ex_imm; r.pc4 = bus.ex_pc4;
        r.op = bus.ex_aluop; r.ctrl = bus.ex_ctrl; r.cnt = bus.bubble_cnt;
        return r;
    endfunction

    // Value the execute stage should see for a source register read this cycle
    function automatic logic [31:0] operand(input logic [5:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (bus.wb_reg_write && bus.wb_addr == a) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic load_use(input st_t s);
        logic loaded;
        loaded = s.v && s.ctrl[CTRL_MEM_READ] && s.rd != 0;
        return loaded && bus.id_valid &&
               ((bus.id_use_rs && bus.id_rs == s.rd) || (bus.id_use_rt && bus.id_rt == s.rd));
    endfunction

    function automatic st_t next_of(input st_t s);
        st_t n;
        n = '0;
        n.cnt = s.cnt;
        if (bus.flush) return n;
        if (bus.hold) return s;
        if (load_use(s)) begin
            if (s.cnt != {CW{1'b1}}) n.cnt = s.cnt + 1;
            return n;
        end
        n.v = bus.id_valid; n.rs = bus.id_rs; n.rt = bus.id_rt; n.rd = bus.id_rd;
        n.d1 = operand(bus.id_rs, bus.id_data1);
        n.d2 = operand(bus.id_rt, bus.id_data2);
        n.imm = bus.id_imm; n.pc4 = bus.id_pc4; n.op = bus.id_aluop;
        n.ctrl = bus.id_valid ? bus.id_ctrl : 5'b0;
        return n;
    endfunction

    // Inputs are already set at the falling edge; check stall, predict the edge, move to next fall
    task automatic tick();
        st_t e;
        #1;
        cmp("stall_id", bus.stall_id, load_use(m) || bus.hold);
        e = next_of(m);
        sb.push_back(e);
        m = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        st_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("ex_regs", dut_st(), e);
        end
    end

    task automatic rand_inputs(input int ctl_rate);
        bus.id_valid = $urandom_range(0, 3) != 0;
        bus.id_rs = 6'($urandom_range(0, 7));
        bus.id_rt = 6'($urandom_range(0, 7));
        bus.id_rd = 6'($urandom_range(0, 7));
        bus.id_use_rs = 1'($urandom);
        bus.id_use_rt = 1'($urandom);
        bus.id_data1 = $urandom; bus.id_data2 = $urandom;
        bus.id_imm = $urandom; bus.id_pc4 = $urandom;
        bus.id_aluop = 4'($urandom);
        bus.id_ctrl = 5'($urandom);
        bus.wb_reg_write = 1'($urandom);
        bus.wb_addr = 6'($urandom_range(0, 7));
        bus.wb_data = $urandom;
        bus.flush = ctl_rate != 0 && $urandom_range(0, ctl_rate - 1) == 0;
        bus.hold = ctl_rate != 0 && $urandom_range(0, ctl_rate - 1) == 0;
    endtask

    task automatic set_instr(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                             input logic urs, input logic urt, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [4:0] ctrl);
        rand_inputs(0);
        bus.id_valid = 1'b1;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_use_rs = urs; bus.id_use_rt = urt;
        bus.id_data1 = d1; bus.id_data2 = d2;
        bus.id_ctrl = ctrl;
        bus.wb_reg_write = 1'b0;
    endtask

    localparam logic [4:0] LW  = 5'b11011;
    localparam logic [4:0] ALU = 5'b00010;

    initial begin
        st_t snap;
        m = '0;
        rand_inputs(0);
        @(negedge clk);

        // Reset while decode presents random traffic
        rst_n = 1'b0;
        repeat (3) begin
            rand_inputs(0);
            @(negedge clk);
        end
        #1;
        cmp("reset_regs", dut_st(), '0);
        cmp("reset_stall", bus.stall_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // add rd=3 with operands 5 and 7
        set_instr(6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 32'd5, 32'd7, ALU);
        tick();
        cmp("add_data1", bus.ex_data1, 32'd5);
        cmp("add_data2", bus.ex_data2, 32'd7);

        // Load-use on rs
        set_instr(6'd1, 6'd2, 6'd4, 1'b1, 1'b0, 32'h100, 32'h0, LW);
        tick();
        set_instr(6'd4, 6'd2, 6'd6, 1'b1, 1'b0, 32'h44, 32'h55, ALU);
        tick();
        cmp("lu_bubble_valid", bus.ex_valid, 1'b0);
        cmp("lu_bubble_cnt", bus.bubble_cnt, CW'(1));
        tick();
        cmp("lu_dep_valid", bus.ex_valid, 1'b1);

        // Writeback bypass, then register-zero operand
        set_instr(6'd1, 6'd9, 6'd2, 1'b1, 1'b1, 32'h1, 32'h11, ALU);
        bus.wb_reg_write = 1'b1; bus.wb_addr = 6'd9; bus.wb_data = 32'hDEADBEEF;
        tick();
        cmp("bypass_rt", bus.ex_data2, 32'hDEADBEEF);
        set_instr(6'd1, 6'd0, 6'd2, 1'b1, 1'b1, 32'h1, 32'h11, ALU);
        bus.wb_reg_write = 1'b1; bus.wb_addr = 6'd0; bus.wb_data = 32'hDEADBEEF;
        tick();
        cmp("zero_rt", bus.ex_data2, 32'h0);

        // Flush wins over hold
        rand_inputs(0);
        bus.flush = 1'b1; bus.hold = 1'b1;
        tick();
        cmp("flush_hold_ctrl", bus.ex_ctrl, 5'b0);

        // Hold for three cycles
        set_instr(6'd3, 6'd4, 6'd5, 1'b1, 1'b1, 32'hA, 32'hB, LW);
        tick();
        snap = dut_st();
        repeat (3) begin
            rand_inputs(0);
            bus.hold = 1'b1;
            tick();
        end
        cmp("hold_unchanged", dut_st(), snap);

        // Qualifiers: load to r0, and unused rt
        set_instr(6'd1, 6'd2, 6'd0, 1'b1, 1'b0, 32'h0, 32'h0, LW);
        tick();
        set_instr(6'd0, 6'd2, 6'd7, 1'b1, 1'b0, 32'h0, 32'h0, ALU);
        tick();
        set_instr(6'd1, 6'd2, 6'd5, 1'b1, 1'b0, 32'h0, 32'h0, LW);
        tick();
        set_instr(6'd1, 6'd5, 6'd7, 1'b0, 1'b0, 32'h0, 32'h0, ALU);
        tick();
        cmp("qual_cnt", bus.bubble_cnt, CW'(1));

        // Reset arriving in the middle of a load-use stall
        set_instr(6'd1, 6'd2, 6'd7, 1'b1, 1'b0, 32'h0, 32'h0, LW);
        tick();
        set_instr(6'd7, 6'd2, 6'd8, 1'b1, 1'b0, 32'h0, 32'h0, ALU);
        #1;
        cmp("midstall_stall", bus.stall_id, 1'b1);
        rst_n = 1'b0;
        #1;
        cmp("midstall_regs", dut_st(), '0);
        cmp("midstall_stall_drop", bus.stall_id, 1'b0);
        m = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        repeat (400) begin
            rand_inputs(8);
            tick();
        end

        // Chained dependent loads until the counter saturates
        repeat (2 * ((1 << CW) + 4)) begin
            set_instr(6'd2, 6'd3, 6'd2, 1'b1, 1'b0, 32'h0, 32'h0, LW);
            tick();
        end
        cmp("cnt_saturated", bus.bubble_cnt, {CW{1'b1}});

        repeat (5) begin
            if (sb.size() != 0) @(negedge clk);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
